// File: rtl/ofm_pkg.sv
// ofm_pkg: shared state encoding, control-word layout and byte-count limits
// for the OFM input framing FSM.
package ofm_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CTRL = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    localparam logic [3:0] FLAG_OK = 4'b1000;

    localparam int CW_BEGIN_LSB  = 0;
    localparam int CW_INSERT_LSB = 16;
    localparam int CW_INIT_LSB   = 32;
    localparam int CW_CNTRL_LSB  = 48;
    localparam int CW_BYTES_LSB  = 50;

    localparam logic [13:0] BYTES_MAX = 14'd16383;

    function automatic logic [13:0] byte_sat_add(input logic [13:0] a, input logic [7:0] b);
        logic [14:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[14] ? BYTES_MAX : s[13:0];
    endfunction

endpackage

// File: rtl/ofm_keep_popcnt.sv
// ofm_keep_popcnt: combinational count of set tkeep bits.
module ofm_keep_popcnt #(
    parameter int C_KEEP_W = 8
) (
    input  logic [C_KEEP_W-1:0] keep,
    output logic [7:0]          cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < C_KEEP_W; i++) cnt = cnt + 8'(keep[i]);
    end

endmodule

// File: rtl/ofm_in_pfsm.sv
// ofm_in_pfsm: parses the txc control packet, then streams the txd frame into
// the data FIFO and writes one checksum/length descriptor per frame.
module ofm_in_pfsm
    import ofm_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_DROP_BAD   = 1
) (
    input  logic                                mm2s_clk,
    input  logic                                mm2s_resetn,
    input  logic [C_DATA_WIDTH-1:0]             txd_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]           txd_tkeep,
    input  logic                                txd_tvalid,
    input  logic                                txd_tlast,
    output logic                                txd_tready,
    input  logic [31:0]                         txc_tdata,
    input  logic [3:0]                          txc_tkeep,
    input  logic                                txc_tvalid,
    input  logic                                txc_tlast,
    output logic                                txc_tready,
    input  logic                                ctrl_fifo_afull,
    output logic                                ctrl_fifo_wren,
    output logic [63:0]                         ctrl_fifo_wdata,
    input  logic                                data_fifo_afull,
    output logic                                data_fifo_wren,
    output logic [C_DATA_WIDTH+C_DATA_WIDTH/8:0] data_fifo_wdata,
    output logic [31:0]                         frame_cnt,
    output logic [31:0]                         drop_cnt,
    output logic [3:0]                          in_fsm_dbg
);

    logic [2:0]  state, state_n;
    logic        afull_c_r, afull_d_r;
    logic [2:0]  idx;
    logic [3:0]  flag, flag_n;
    logic [1:0]  cs_cntrl;
    logic [15:0] cs_begin, cs_insert, cs_init;
    logic [13:0] bytes, bytes_n;
    logic [7:0]  pop;
    logic        c_acc, d_acc, data_acc, drop_bad;
    logic        unused_keep;

    assign unused_keep = ^txc_tkeep;

    ofm_keep_popcnt #(.C_KEEP_W(C_DATA_WIDTH/8)) u_popcnt (
        .keep (txd_tkeep),
        .cnt  (pop)
    );

    assign txc_tready = state == ST_CTRL;
    assign txd_tready = state == ST_DATA || state == ST_DROP;
    assign c_acc      = txc_tvalid && txc_tready;
    assign d_acc      = txd_tvalid && txd_tready;
    assign data_acc   = d_acc && state == ST_DATA;
    assign in_fsm_dbg = {1'b0, state};
    assign bytes_n    = byte_sat_add(bytes, pop);
    // A one-word control packet ends on the flag word itself, so judge the live flag.
    assign flag_n     = idx == 3'd0 ? txc_tdata[31:28] : flag;
    assign drop_bad   = flag_n != FLAG_OK && C_DROP_BAD != 0;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = txc_tvalid && !afull_c_r ? ST_CTRL : ST_IDLE;
            ST_CTRL: state_n = c_acc && txc_tlast ? (drop_bad ? ST_DROP : ST_WAIT) : ST_CTRL;
            ST_WAIT: state_n = txd_tvalid && !afull_d_r ? ST_DATA : ST_WAIT;
            ST_DATA, ST_DROP: state_n = txd_tvalid && txd_tlast ? ST_IDLE : state;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            state           <= ST_IDLE;
            afull_c_r       <= 1'b0;
            afull_d_r       <= 1'b0;
            idx             <= '0;
            flag            <= '0;
            cs_cntrl        <= '0;
            cs_begin        <= '0;
            cs_insert       <= '0;
            cs_init         <= '0;
            bytes           <= '0;
            data_fifo_wren  <= 1'b0;
            data_fifo_wdata <= '0;
            ctrl_fifo_wren  <= 1'b0;
            ctrl_fifo_wdata <= '0;
            frame_cnt       <= '0;
            drop_cnt        <= '0;
        end else begin
            state          <= state_n;
            afull_c_r      <= ctrl_fifo_afull;
            afull_d_r      <= data_fifo_afull;
            data_fifo_wren <= data_acc;
            ctrl_fifo_wren <= data_acc && txd_tlast;
            if (data_acc) data_fifo_wdata <= {txd_tlast, txd_tkeep, txd_tdata};
            if (state == ST_IDLE) begin
                idx       <= '0;
                flag      <= '0;
                cs_cntrl  <= '0;
                cs_begin  <= '0;
                cs_insert <= '0;
                cs_init   <= '0;
                bytes     <= '0;
            end else begin
                if (c_acc) begin
                    idx <= idx == 3'd7 ? 3'd7 : idx + 3'd1;
                    case (idx)
                        3'd0: flag <= txc_tdata[31:28];
                        3'd1: cs_cntrl <= txc_tdata[1:0];
                        3'd2: {cs_begin, cs_insert} <= txc_tdata;
                        3'd3: cs_init <= txc_tdata[15:0];
                        default: ;
                    endcase
                end
                if (data_acc) bytes <= bytes_n;
            end
            if (data_acc && txd_tlast) begin
                ctrl_fifo_wdata <= {bytes_n, cs_cntrl, cs_init, cs_insert, cs_begin};
                frame_cnt       <= frame_cnt + 32'd1;
            end
            if (state == ST_DROP && d_acc && txd_tlast) drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ofm_in_pfsm.sv
// tb_ofm_in_pfsm: directed checks on three builds (64/drop, 64/forward, 128/drop)
// fed the same streams, each with its own valid so handshakes stay independent.
module tb_ofm_in_pfsm;

    logic           mm2s_clk = 1'b0;
    logic           mm2s_resetn = 1'b0;
    logic [127:0]   td = '0;
    logic [15:0]    tk = '0;
    logic           tl = 1'b0;
    logic [31:0]    cd = '0;
    logic           cl = 1'b0;
    logic [2:0]     cv = '0, dv = '0, cr, dr, cwr, dwr;
    logic           afc = 1'b0, afd = 1'b0;
    logic [63:0]    cwd [3];
    logic [31:0]    fc [3], dc [3];
    logic [3:0]     dbg [3];
    logic [72:0]    dd0, dd1;
    logic [144:0]   dd2;
    logic [31:0]    cw_tab [4];
    int             total = 0, bad = 0;
    int             nd [3] = '{0, 0, 0}, nc [3] = '{0, 0, 0}, nsolo = 0;
    int             nd0 [3], nc0 [3];
    logic [63:0]    lastc [3];
    logic [72:0]    ld0;
    logic [144:0]   ld2;
    logic [127:0]   last_td;
    int             seq = 0;

    always #5 mm2s_clk = ~mm2s_clk;

    ofm_in_pfsm #(.C_DATA_WIDTH(64), .C_DROP_BAD(1)) u_d64 (
        .mm2s_clk(mm2s_clk), .mm2s_resetn(mm2s_resetn),
        .txd_tdata(td[63:0]), .txd_tkeep(tk[7:0]), .txd_tvalid(dv[0]), .txd_tlast(tl), .txd_tready(dr[0]),
        .txc_tdata(cd), .txc_tkeep(4'hF), .txc_tvalid(cv[0]), .txc_tlast(cl), .txc_tready(cr[0]),
        .ctrl_fifo_afull(afc), .ctrl_fifo_wren(cwr[0]), .ctrl_fifo_wdata(cwd[0]),
        .data_fifo_afull(afd), .data_fifo_wren(dwr[0]), .data_fifo_wdata(dd0),
        .frame_cnt(fc[0]), .drop_cnt(dc[0]), .in_fsm_dbg(dbg[0]));

    ofm_in_pfsm #(.C_DATA_WIDTH(64), .C_DROP_BAD(0)) u_f64 (
        .mm2s_clk(mm2s_clk), .mm2s_resetn(mm2s_resetn),
        .txd_tdata(td[63:0]), .txd_tkeep(tk[7:0]), .txd_tvalid(dv[1]), .txd_tlast(tl), .txd_tready(dr[1]),
        .txc_tdata(cd), .txc_tkeep(4'hF), .txc_tvalid(cv[1]), .txc_tlast(cl), .txc_tready(cr[1]),
        .ctrl_fifo_afull(afc), .ctrl_fifo_wren(cwr[1]), .ctrl_fifo_wdata(cwd[1]),
        .data_fifo_afull(afd), .data_fifo_wren(dwr[1]), .data_fifo_wdata(dd1),
        .frame_cnt(fc[1]), .drop_cnt(dc[1]), .in_fsm_dbg(dbg[1]));

    ofm_in_pfsm #(.C_DATA_WIDTH(128), .C_DROP_BAD(1)) u_d128 (
        .mm2s_clk(mm2s_clk), .mm2s_resetn(mm2s_resetn),
        .txd_tdata(td), .txd_tkeep(tk), .txd_tvalid(dv[2]), .txd_tlast(tl), .txd_tready(dr[2]),
        .txc_tdata(cd), .txc_tkeep(4'hF), .txc_tvalid(cv[2]), .txc_tlast(cl), .txc_tready(cr[2]),
        .ctrl_fifo_afull(afc), .ctrl_fifo_wren(cwr[2]), .ctrl_fifo_wdata(cwd[2]),
        .data_fifo_afull(afd), .data_fifo_wren(dwr[2]), .data_fifo_wdata(dd2),
        .frame_cnt(fc[2]), .drop_cnt(dc[2]), .in_fsm_dbg(dbg[2]));

    always @(negedge mm2s_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dwr[k]) nd[k]++;
            if (cwr[k]) begin
                nc[k]++;
                lastc[k] = cwd[k];
                if (!dwr[k]) nsolo++;
            end
        end
        if (dwr[0]) ld0 = dd0;
        if (dwr[2]) ld2 = dd2;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mm2s_clk);
        #1;
    endtask

    task automatic wait_acc(input bit is_c);
        logic [2:0] acc;
        int n;
        n = 0;
        while ((is_c ? cv : dv) != 3'b000 && n < 100) begin
            @(negedge mm2s_clk);
            acc = is_c ? (cv & cr) : (dv & dr);
            @(posedge mm2s_clk);
            #1;
            if (is_c) cv = cv & ~acc;
            else dv = dv & ~acc;
            n++;
        end
        if (n >= 100) begin
            check(is_c ? "txc_timeout" : "txd_timeout", 64'(is_c ? cv : dv), 64'd0);
            cv = '0;
            dv = '0;
        end
    endtask

    task automatic send_ctrl(input int n);
        for (int i = 0; i < n; i++) begin
            cd = cw_tab[i];
            cl = i == n - 1;
            cv = 3'b111;
            wait_acc(1'b1);
        end
        cl = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] keep, input bit last);
        seq++;
        td = {4{32'(seq)}};
        last_td = td;
        tk = keep;
        tl = last;
        dv = 3'b111;
        wait_acc(1'b0);
        tl = 1'b0;
    endtask

    task automatic snap;
        for (int k = 0; k < 3; k++) begin
            nd0[k] = nd[k];
            nc0[k] = nc[k];
        end
    endtask

    initial begin
        cw_tab = '{32'h8000_0000, 32'h0000_0002, 32'h000E_0030, 32'h0000_1234};
        tick(2);
        check("rst_txc_tready", 64'(cr), 64'd0);
        check("rst_wren", 64'({cwr, dwr}), 64'd0);
        check("rst_cwdata", cwd[0], 64'd0);
        check("rst_dbg", 64'(dbg[0]), 64'd0);
        check("rst_fcnt", 64'(fc[0]), 64'd0);
        @(negedge mm2s_clk);
        mm2s_resetn = 1'b1;
        tick(2);

        // txd offered while idle is neither accepted nor written
        tl = 1'b1;
        tk = 16'hFFFF;
        dv = 3'b111;
        tick(4);
        check("idle_txd_tready", 64'(dr), 64'd0);
        check("idle_no_data_wr", 64'(nd[0] + nd[1] + nd[2]), 64'd0);
        dv = '0;
        tl = 1'b0;

        // good frame, keep FF FF 0F
        snap();
        send_ctrl(4);
        check("wait_txd_tready", 64'(dr), 64'd0);
        check("wait_dbg", 64'(dbg[0]), 64'(3'd2));
        send_beat(16'h00FF, 1'b0);
        send_beat(16'h00FF, 1'b0);
        send_beat(16'h000F, 1'b1);
        tick(3);
        check("good_data_wr", 64'(nd[0] - nd0[0]), 64'd3);
        check("good_ctrl_wr", 64'(nc[0] - nc0[0]), 64'd1);
        check("good_cwdata", lastc[0], {14'd20, 2'd2, 16'h1234, 16'h0030, 16'h000E});
        check("good_last_hi", 64'(ld0[72:64]), 64'h10F);
        check("good_last_lo", ld0[63:0], last_td[63:0]);
        check("good_fcnt", 64'(fc[0]), 64'd1);
        check("good_cwdata_128", lastc[2], {14'd20, 2'd2, 16'h1234, 16'h0030, 16'h000E});

        // bad flag: dropped by drop builds, forwarded by u_f64
        snap();
        cw_tab[0] = 32'h1000_0000;
        send_ctrl(4);
        check("drop_dbg", 64'(dbg[0]), 64'(3'd4));
        for (int i = 0; i < 4; i++) send_beat(16'h00FF, i == 3);
        tick(3);
        check("drop_data_wr", 64'(nd[0] - nd0[0]), 64'd0);
        check("drop_ctrl_wr", 64'(nc[0] - nc0[0]), 64'd0);
        check("drop_dcnt", 64'(dc[0]), 64'd1);
        check("drop_fcnt", 64'(fc[0]), 64'd1);
        check("drop_dcnt_128", 64'(dc[2]), 64'd1);
        check("fwd_data_wr", 64'(nd[1] - nd0[1]), 64'd4);
        check("fwd_cwdata", lastc[1], {14'd32, 2'd2, 16'h1234, 16'h0030, 16'h000E});
        check("fwd_fcnt", 64'(fc[1]), 64'd2);
        check("fwd_dcnt", 64'(dc[1]), 64'd0);

        // short control packet, single-beat frame, keep 00FF
        snap();
        cw_tab[0] = 32'h8000_0000;
        send_ctrl(1);
        send_beat(16'h00FF, 1'b1);
        tick(3);
        check("single_data_wr", 64'(nd[2] - nd0[2]), 64'd1);
        check("single_ctrl_wr", 64'(nc[2] - nc0[2]), 64'd1);
        check("single_cwdata_128", lastc[2], {14'd8, 50'd0});
        check("single_cwdata_64", lastc[0], {14'd8, 50'd0});
        check("single_last_128", 64'(ld2[144:128]), 64'h100FF);
        check("single_same_cycle", 64'(nsolo), 64'd0);

        // ctrl FIFO almost full holds off the control stream
        afc = 1'b1;
        tick(2);
        cd = 32'h8000_0000;
        cl = 1'b1;
        cv = 3'b111;
        tick(3);
        check("afull_txc_tready", 64'(cr), 64'd0);
        check("afull_dbg", 64'(dbg[0]), 64'd0);
        afc = 1'b0;
        tick(1);
        check("afull_1cyc", 64'(cr), 64'd0);
        tick(1);
        check("afull_2cyc", 64'(cr), 64'b111);
        snap();
        send_ctrl(1);
        send_beat(16'h0000, 1'b0);
        send_beat(16'h0081, 1'b1);
        tick(3);
        check("keep0_cwdata", lastc[0], {14'd2, 50'd0});
        check("keep0_fcnt", 64'(fc[0]), 64'd3);

        // byte count saturation
        snap();
        send_ctrl(1);
        for (int i = 0; i < 2050; i++) send_beat(16'hFFFF, i == 2049);
        tick(3);
        check("sat_data_wr", 64'(nd[0] - nd0[0]), 64'd2050);
        check("sat_cwdata", lastc[0], {14'h3FFF, 50'd0});
        check("sat_cwdata_128", lastc[2], {14'h3FFF, 50'd0});

        // reset during the second data beat
        cw_tab[0] = 32'h8000_0000;
        send_ctrl(4);
        send_beat(16'h00FF, 1'b0);
        seq++;
        td = {4{32'(seq)}};
        dv = 3'b111;
        mm2s_resetn = 1'b0;
        #1;
        check("rst_mid_wren", 64'({cwr, dwr}), 64'd0);
        check("rst_mid_ready", 64'({cr, dr}), 64'd0);
        check("rst_mid_ddata", dd0[63:0], 64'd0);
        check("rst_mid_fcnt", 64'(fc[0]), 64'd0);
        dv = '0;
        @(negedge mm2s_clk);
        mm2s_resetn = 1'b1;
        tick(2);
        snap();
        send_ctrl(4);
        send_beat(16'h00FF, 1'b0);
        send_beat(16'h00FF, 1'b0);
        send_beat(16'h000F, 1'b1);
        tick(3);
        check("post_rst_data_wr", 64'(nd[0] - nd0[0]), 64'd3);
        check("post_rst_cwdata", lastc[0], {14'd20, 2'd2, 16'h1234, 16'h0030, 16'h000E});
        check("post_rst_fcnt", 64'(fc[0]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofm_in_pfsm.md
OFM_IN_PFSM -- requirements
Module: ofm_in_pfsm

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, txd datapath width in bits; legal values 64 and 128.
REQ-002 SHALL have parameter C_DROP_BAD, default 1; 1 discards frames with a bad flag, 0 forwards them.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, as follows.
REQ-004 mm2s_clk  in  1  sole clock.
REQ-005 mm2s_resetn  in  1  asynchronous active-low reset.
REQ-006 txd_tdata/txd_tkeep/txd_tvalid/txd_tlast  in  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  AXI-S data stream; txd_tready  out  1.
REQ-007 txc_tdata/txc_tkeep/txc_tvalid/txc_tlast  in  32/4/1/1  AXI-S control stream; txc_tready  out  1.
REQ-008 ctrl_fifo_afull  in  1; ctrl_fifo_wren  out  1; ctrl_fifo_wdata  out  64.
REQ-009 data_fifo_afull  in  1; data_fifo_wren  out  1; data_fifo_wdata  out  C_DATA_WIDTH+C_DATA_WIDTH/8+1  layout {tlast, tkeep, tdata}, MSB to LSB.
REQ-010 frame_cnt  out  32  frames written to ctrl FIFO; drop_cnt  out  32  frames discarded.
REQ-011 in_fsm_dbg  out  4  {0, state[2:0]}.

Function
REQ-012 States: IDLE, CTRL, WAIT, DATA, DROP.
REQ-013 Transitions:
- IDLE->CTRL: txc_tvalid && !afull_c_r.
- CTRL->WAIT: txc_tvalid && txc_tlast, when flag is good or C_DROP_BAD=0.
- CTRL->DROP: txc_tvalid && txc_tlast, when flag is bad and C_DROP_BAD=1.
- WAIT->DATA: txd_tvalid && !afull_d_r.
- DATA->IDLE and DROP->IDLE: txd_tvalid && txd_tlast.
REQ-014 afull_c_r and afull_d_r SHALL be the afull inputs registered once; afull SHALL NOT stall mid-frame (FIFO thresholds must cover one frame).
REQ-015 txc_tready SHALL equal (state==CTRL); txd_tready SHALL equal (state==DATA || state==DROP).
REQ-016 A control word index counter SHALL clear in IDLE, increment per accepted txc beat, and saturate at 7.
REQ-017 Control field capture per index:
- 0: flag=[31:28].
- 1: cs_cntrl=[1:0].
- 2: cs_begin=[31:16], cs_insert=[15:0].
- 3: cs_init=[15:0].
- Index >=4: ignored.
REQ-018 All captured fields SHALL clear in IDLE, so a short control packet leaves the missing fields at 0.
REQ-019 Good flag is exactly 4'b1000; any other value is bad.
REQ-020 Each beat accepted in DATA SHALL produce data_fifo_wren=1 one cycle later with the registered {tlast,tkeep,tdata}.
REQ-021 DROP SHALL accept beats but never assert either wren.
REQ-022 A byte counter SHALL clear in IDLE and add popcount(tkeep) per accepted DATA beat; tkeep=0 adds 0.
REQ-023 The byte counter SHALL saturate at 16383.
REQ-024 On the last DATA beat, ctrl_fifo_wren SHALL pulse one cycle later, in the same cycle as that beat's data_fifo_wren.
REQ-025 ctrl_fifo_wdata layout:
- [15:0] cs_begin.
- [31:16] cs_insert.
- [47:32] cs_init.
- [49:48] cs_cntrl.
- [63:50] byte count including the last beat, saturating.
REQ-026 frame_cnt SHALL increment on each ctrl_fifo_wren; drop_cnt SHALL increment on the DROP->IDLE transition; both wrap at 2^32.
REQ-027 A single-beat frame (tlast on first DATA beat) SHALL produce exactly one data write and one ctrl write in the same cycle.
REQ-028 txd beats presented outside DATA/DROP SHALL NOT be accepted and SHALL produce no writes.

Reset
REQ-029 Asserting mm2s_resetn low SHALL asynchronously force:
- state=IDLE.
- all wren=0 and all wdata=0.
- counters, captured fields and byte count = 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no further writes; recovery of a partial frame already in the FIFO is owned downstream.

Structure
REQ-031 Package ofm_pkg SHALL hold the state encoding, FLAG_OK=4'b1000, the ctrl_fifo_wdata bit offsets, and the byte-count saturation limit.
REQ-032 Sub-module ofm_keep_popcnt SHALL be the combinational tkeep popcount, parametrised by C_DATA_WIDTH/8.

Verification
REQ-033 Good frame (64-bit), ctrl words {8000_0000, 0000_0002, 000E_0030, 0000_1234}, three txd beats with keep FF, FF, 0F -> three data writes; one ctrl write with wdata = {count 20, cntrl 2, init 1234, insert 0030, begin 000E}; frame_cnt=1.
REQ-034 Bad flag 4'b0001, C_DROP_BAD=1, four txd beats -> all beats accepted, zero writes, drop_cnt=1; with C_DROP_BAD=0 -> forwarded like REQ-033.
REQ-035 ctrl_fifo_afull=1 while txc_tvalid=1 -> txc_tready stays 0; afull drop -> txc_tready=1 two cycles later.
REQ-036 128-bit build, single beat, keep=16'h00FF, tlast=1 -> one data write and one ctrl write in the same cycle, count=8.
REQ-037 Short control packet (one word 8000_0000 with tlast) -> ctrl write has cs fields all 0.
REQ-038 Reset asserted during the second DATA beat -> outputs 0 immediately; next frame is processed normally from IDLE.
